// File: rtl/acc_responder.sv
// acc_responder: accelerator-side endpoint of the offload protocol.
// It accepts q-channel requests, forwards hits to the local functional unit,
// turns address misses into error responses, and returns every response on
// the p channel in acceptance order with the request ID echoed back.
//
// Handshake rule for every channel here (q, p, unit_req, unit_rsp): a beat
// transfers on a rising clk_i edge where valid and ready are both 1. Once a
// source raises valid it holds valid and payload stable until the transfer,
// and valid never waits on ready. Ready may depend combinationally on valid
// and payload (q_ready_o looks at q_addr_i).

package acc_pkg;
    parameter int unsigned AccAddrWidth = 4;
endpackage

module acc_responder #(
    parameter int unsigned AccAddrWidth = acc_pkg::AccAddrWidth,
    parameter int unsigned DataWidth = 32,
    parameter int unsigned IdWidth = 6,
    parameter logic [AccAddrWidth-1:0] Addr = '0,
    parameter int unsigned MaxOutstanding = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    q_valid_i,
    output logic                    q_ready_o,
    input  logic [AccAddrWidth-1:0] q_addr_i,
    input  logic [IdWidth-1:0]      q_id_i,
    input  logic [31:0]             q_data_op_i,
    input  logic [DataWidth-1:0]    q_data_arga_i,
    input  logic [DataWidth-1:0]    q_data_argb_i,
    input  logic [DataWidth-1:0]    q_data_argc_i,
    output logic                    p_valid_o,
    input  logic                    p_ready_i,
    output logic [IdWidth-1:0]      p_id_o,
    output logic [DataWidth-1:0]    p_data_o,
    output logic                    p_error_o,
    output logic                    unit_req_valid_o,
    input  logic                    unit_req_ready_i,
    output logic [31:0]             unit_op_o,
    output logic [DataWidth-1:0]    unit_arga_o,
    output logic [DataWidth-1:0]    unit_argb_o,
    output logic [DataWidth-1:0]    unit_argc_o,
    input  logic                    unit_rsp_valid_i,
    output logic                    unit_rsp_ready_o,
    input  logic [DataWidth-1:0]    unit_rsp_data_i,
    input  logic                    unit_rsp_error_i
);
    // MaxOutstanding is a power of two, so pointers wrap by plain overflow.
    localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
    localparam int unsigned CntW = PtrW + 1;

    typedef struct packed {
        logic [IdWidth-1:0] id;
        logic               miss;
    } entry_t;

    entry_t                mem_q [MaxOutstanding];
    entry_t                mem_d [MaxOutstanding];
    logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]       count_q, count_d;
    logic [CntW-1:0]       hits_q, hits_d;
    logic                  p_valid_q, p_valid_d;
    logic [IdWidth-1:0]    p_id_q, p_id_d;
    logic [DataWidth-1:0]  p_data_q, p_data_d;
    logic                  p_error_q, p_error_d;

    entry_t head;
    logic   hit, full, nonempty, push, push_hit, pop, out_free, load_miss, load_hit;

    // Request side: address check, issue gating and tracking-FIFO push.
    assign hit      = (q_addr_i == Addr);
    assign full     = (count_q == CntW'(MaxOutstanding));
    assign nonempty = (count_q != '0);
    assign head     = mem_q[rd_ptr_q];

    // No full pass-through: a pop in the same cycle does not open q_ready_o.
    assign q_ready_o        = ~full & (~hit | unit_req_ready_i);
    assign unit_req_valid_o = q_valid_i & hit & ~full;
    assign push             = q_valid_i & q_ready_o;
    assign push_hit         = push & hit;

    assign unit_op_o   = q_data_op_i;
    assign unit_arga_o = q_data_arga_i;
    assign unit_argb_o = q_data_argb_i;
    assign unit_argc_o = q_data_argc_i;

    // Response side: the head entry decides whether the output register is
    // fed by a unit result (hit) or by a locally made error beat (miss).
    assign out_free         = ~p_valid_q | p_ready_i;
    assign unit_rsp_ready_o = nonempty & ~head.miss & out_free;
    assign load_miss        = nonempty & head.miss & out_free;
    assign load_hit         = unit_rsp_valid_i & unit_rsp_ready_o;
    assign pop              = load_miss | load_hit;

    assign p_valid_o = p_valid_q;
    assign p_id_o    = p_id_q;
    assign p_data_o  = p_data_q;
    assign p_error_o = p_error_q;

    // Next-state for the tracking FIFO, the hit counter and the output register.
    always_comb begin
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        hits_d    = hits_q;
        p_valid_d = p_valid_q;
        p_id_d    = p_id_q;
        p_data_d  = p_data_q;
        p_error_d = p_error_q;

        if (push) begin
            mem_d[wr_ptr_q] = '{id: q_id_i, miss: ~hit};
            wr_ptr_d        = wr_ptr_q + PtrW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase

        // Outstanding hits only feed the unit-result sanity check.
        if (push_hit && !load_hit) begin
            hits_d = hits_q + CntW'(1);
        end else if (!push_hit && load_hit) begin
            hits_d = hits_q - CntW'(1);
        end

        if (load_miss) begin
            p_valid_d = 1'b1;
            p_id_d    = head.id;
            p_data_d  = '0;
            p_error_d = 1'b1;
        end else if (load_hit) begin
            p_valid_d = 1'b1;
            p_id_d    = head.id;
            p_data_d  = unit_rsp_data_i;
            p_error_d = unit_rsp_error_i;
        end else if (out_free) begin
            p_valid_d = 1'b0;
        end
    end

    // State registers with synchronous reset; reset drops every entry.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < MaxOutstanding; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            hits_q    <= '0;
            p_valid_q <= 1'b0;
            p_id_q    <= '0;
            p_data_q  <= '0;
            p_error_q <= 1'b0;
        end else begin
            mem_q     <= mem_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            hits_q    <= hits_d;
            p_valid_q <= p_valid_d;
            p_id_q    <= p_id_d;
            p_data_q  <= p_data_d;
            p_error_q <= p_error_d;
        end
    end

    a_no_push_full: assert property (@(posedge clk_i) disable iff (rst_i)
        !(push && full));
    a_no_pop_empty: assert property (@(posedge clk_i) disable iff (rst_i)
        !(pop && !nonempty));
    a_p_stable: assert property (@(posedge clk_i) disable iff (rst_i)
        (p_valid_q && !p_ready_i) |=>
        (p_valid_q && $stable(p_id_q) && $stable(p_data_q) && $stable(p_error_q)));
    a_rsp_with_hits: assert property (@(posedge clk_i) disable iff (rst_i)
        unit_rsp_valid_i |-> (hits_q != '0))
        else $warning("unit result offered with no outstanding hit");

endmodule

// File: tb/tb_acc_responder.sv
// Bench for acc_responder: clock/reset, driver tasks, a unit model, an
// expected-response queue checked on every p beat, and a final report.
module tb_acc_responder;
    localparam int AW   = acc_pkg::AccAddrWidth;
    localparam int DW   = 32;
    localparam int IW   = 6;
    localparam int MAXO = 4;
    localparam logic [AW-1:0] ADDR = '0;
    localparam int EW   = IW + DW + 1;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          q_valid_i, q_ready_o;
    logic [AW-1:0] q_addr_i;
    logic [IW-1:0] q_id_i;
    logic [31:0]   q_data_op_i;
    logic [DW-1:0] q_data_arga_i, q_data_argb_i, q_data_argc_i;
    logic          p_valid_o, p_ready_i;
    logic [IW-1:0] p_id_o;
    logic [DW-1:0] p_data_o;
    logic          p_error_o;
    logic          unit_req_valid_o, unit_req_ready_i;
    logic [31:0]   unit_op_o;
    logic [DW-1:0] unit_arga_o, unit_argb_o, unit_argc_o;
    logic          unit_rsp_valid_i, unit_rsp_ready_o;
    logic [DW-1:0] unit_rsp_data_i;
    logic          unit_rsp_error_i;

    acc_responder #(
        .AccAddrWidth(AW), .DataWidth(DW), .IdWidth(IW), .Addr(ADDR), .MaxOutstanding(MAXO)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .q_valid_i(q_valid_i), .q_ready_o(q_ready_o), .q_addr_i(q_addr_i), .q_id_i(q_id_i),
        .q_data_op_i(q_data_op_i), .q_data_arga_i(q_data_arga_i),
        .q_data_argb_i(q_data_argb_i), .q_data_argc_i(q_data_argc_i),
        .p_valid_o(p_valid_o), .p_ready_i(p_ready_i), .p_id_o(p_id_o),
        .p_data_o(p_data_o), .p_error_o(p_error_o),
        .unit_req_valid_o(unit_req_valid_o), .unit_req_ready_i(unit_req_ready_i),
        .unit_op_o(unit_op_o), .unit_arga_o(unit_arga_o), .unit_argb_o(unit_argb_o),
        .unit_argc_o(unit_argc_o),
        .unit_rsp_valid_i(unit_rsp_valid_i), .unit_rsp_ready_o(unit_rsp_ready_o),
        .unit_rsp_data_i(unit_rsp_data_i), .unit_rsp_error_i(unit_rsp_error_i)
    );

    // Clock
    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [DW-1:0] data;
        logic          err;
        int            due;
    } pend_t;

    typedef struct packed {
        logic          v;
        logic [AW-1:0] a;
        logic          urr;
        logic          e_urv;
        logic          e_qr;
    } vec_t;

    logic [EW-1:0] exp_q[$];
    pend_t         pend_q[$];
    vec_t          vecs[8];
    int            total = 0;
    int            bad = 0;
    int            cyc = 0;
    int            unit_lat = 1;
    logic          unit_hold = 1'b0;
    logic          last_acc = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // The functional unit used by the bench: xor of operands and opcode,
    // error flagged by opcode bit 31.
    function automatic logic [DW-1:0] unit_fn(input logic [31:0] op, input logic [DW-1:0] a,
                                              input logic [DW-1:0] b, input logic [DW-1:0] c);
        return a ^ b ^ c ^ op;
    endfunction

    // Response a request must eventually produce: hits carry the unit's
    // answer, misses carry zero data and the error flag.
    function automatic logic [EW-1:0] expect_rsp(input logic [AW-1:0] a, input logic [IW-1:0] id,
                                                 input logic [31:0] op, input logic [DW-1:0] x,
                                                 input logic [DW-1:0] y, input logic [DW-1:0] z);
        if (a == ADDR) return {id, unit_fn(op, x, y, z), op[31]};
        return {id, {DW{1'b0}}, 1'b1};
    endfunction

    // Drive unit response for this cycle, then settle to the sample point.
    task automatic begin_cycle();
        if (!unit_hold && pend_q.size() > 0 && pend_q[0].due <= cyc) begin
            unit_rsp_valid_i = 1'b1;
            unit_rsp_data_i  = pend_q[0].data;
            unit_rsp_error_i = pend_q[0].err;
        end else begin
            unit_rsp_valid_i = 1'b0;
            unit_rsp_data_i  = '0;
            unit_rsp_error_i = 1'b0;
        end
        #2;
    endtask

    // Observe handshakes of this cycle, run the scoreboard, advance a clock.
    task automatic end_cycle();
        pend_t         pe;
        logic [EW-1:0] e;
        last_acc = 1'b0;
        if (unit_req_valid_o && unit_req_ready_i) begin
            pe.data = unit_fn(unit_op_o, unit_arga_o, unit_argb_o, unit_argc_o);
            pe.err  = unit_op_o[31];
            pe.due  = cyc + unit_lat;
            pend_q.push_back(pe);
        end
        if (unit_rsp_valid_i && unit_rsp_ready_o) pe = pend_q.pop_front();
        if (q_valid_i && q_addr_i != ADDR) chk("miss_not_issued", 64'(unit_req_valid_o), 64'd0);
        if (q_valid_i && q_ready_o) begin
            exp_q.push_back(expect_rsp(q_addr_i, q_id_i, q_data_op_i,
                                       q_data_arga_i, q_data_argb_i, q_data_argc_i));
            last_acc = 1'b1;
        end
        if (p_valid_o && p_ready_i) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_unexpected: got beat id %0h with nothing expected", p_id_o);
            end else begin
                e = exp_q.pop_front();
                chk("sb_beat", 64'({p_id_o, p_data_o, p_error_o}), 64'(e));
            end
        end
        @(posedge clk_i);
        #1;
        cyc++;
    endtask

    task automatic set_req(input logic [AW-1:0] a, input logic [IW-1:0] id);
        q_valid_i     = 1'b1;
        q_addr_i      = a;
        q_id_i        = id;
        q_data_op_i   = $urandom();
        q_data_arga_i = $urandom();
        q_data_argb_i = $urandom();
        q_data_argc_i = $urandom();
    endtask

    task automatic do_reset();
        rst_i            = 1'b1;
        q_valid_i        = 1'b0;
        unit_rsp_valid_i = 1'b0;
        unit_rsp_data_i  = '0;
        unit_rsp_error_i = 1'b0;
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        pend_q.delete();
        exp_q.delete();
        cyc++;
    endtask

    task automatic drain(input string name);
        int n = 0;
        q_valid_i        = 1'b0;
        p_ready_i        = 1'b1;
        unit_hold        = 1'b0;
        unit_req_ready_i = 1'b1;
        while ((exp_q.size() != 0 || p_valid_o) && n < 100) begin
            begin_cycle();
            end_cycle();
            n++;
        end
        chk(name, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i = 1'b1; q_valid_i = 1'b0; q_addr_i = '0; q_id_i = '0; q_data_op_i = '0;
        q_data_arga_i = '0; q_data_argb_i = '0; q_data_argc_i = '0;
        p_ready_i = 1'b1; unit_req_ready_i = 1'b0;
        unit_rsp_valid_i = 1'b0; unit_rsp_data_i = '0; unit_rsp_error_i = 1'b0;

        // v, addr, unit_req_ready -> unit_req_valid, q_ready (empty FIFO)
        vecs[0] = '{1'b1, AW'(0),  1'b1, 1'b1, 1'b1};
        vecs[1] = '{1'b1, AW'(0),  1'b0, 1'b1, 1'b0};
        vecs[2] = '{1'b1, AW'(3),  1'b0, 1'b0, 1'b1};
        vecs[3] = '{1'b1, AW'(3),  1'b1, 1'b0, 1'b1};
        vecs[4] = '{1'b0, AW'(0),  1'b1, 1'b0, 1'b1};
        vecs[5] = '{1'b0, AW'(0),  1'b0, 1'b0, 1'b0};
        vecs[6] = '{1'b0, AW'(5),  1'b0, 1'b0, 1'b1};
        vecs[7] = '{1'b1, AW'(15), 1'b1, 1'b0, 1'b1};

        do_reset();

        // Reset state
        #2;
        chk("rst_p_valid", 64'(p_valid_o), 64'd0);
        chk("rst_p_id", 64'(p_id_o), 64'd0);
        chk("rst_p_data", 64'(p_data_o), 64'd0);
        chk("rst_p_error", 64'(p_error_o), 64'd0);
        chk("rst_rsp_ready", 64'(unit_rsp_ready_o), 64'd0);
        chk("rst_q_ready", 64'(q_ready_o), 64'd0);
        @(posedge clk_i);
        #1;
        cyc++;

        // Combinational q-side table, no request ever lands on a clock edge
        for (int i = 0; i < 8; i++) begin
            set_req(vecs[i].a, IW'(i));
            q_valid_i        = vecs[i].v;
            unit_req_ready_i = vecs[i].urr;
            #2;
            chk($sformatf("vec%0d_issue", i), 64'(unit_req_valid_o), 64'(vecs[i].e_urv));
            chk($sformatf("vec%0d_qready", i), 64'(q_ready_o), 64'(vecs[i].e_qr));
            chk("vec_op_pass", 64'(unit_op_o), 64'(q_data_op_i));
            chk("vec_arg_pass", 64'({unit_arga_o ^ unit_argb_o ^ unit_argc_o}),
                64'(q_data_arga_i ^ q_data_argb_i ^ q_data_argc_i));
            q_valid_i = 1'b0;
            @(posedge clk_i);
            #1;
            cyc++;
        end

        // Single hit, unit answers 3 cycles after issue
        p_ready_i = 1'b1; unit_lat = 3; unit_req_ready_i = 1'b1;
        set_req(ADDR, 6'h2A);
        q_data_op_i = '0; q_data_arga_i = 32'hDEADBEEF; q_data_argb_i = '0; q_data_argc_i = '0;
        begin_cycle();
        chk("hit_issue", 64'(unit_req_valid_o), 64'd1);
        chk("hit_qready", 64'(q_ready_o), 64'd1);
        end_cycle();
        q_valid_i = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            begin_cycle();
            chk("hit_wait_pvalid", 64'(p_valid_o), 64'd0);
            if (k == 3) chk("hit_rsp_ready", 64'(unit_rsp_ready_o & unit_rsp_valid_i), 64'd1);
            end_cycle();
        end
        begin_cycle();
        chk("hit_p_valid", 64'(p_valid_o), 64'd1);
        chk("hit_p_id", 64'(p_id_o), 64'h2A);
        chk("hit_p_data", 64'(p_data_o), 64'hDEADBEEF);
        chk("hit_p_error", 64'(p_error_o), 64'd0);
        end_cycle();
        begin_cycle();
        chk("hit_p_clear", 64'(p_valid_o), 64'd0);
        end_cycle();

        // Miss into an empty FIFO: response two cycles after accept
        unit_req_ready_i = 1'b0;
        set_req(AW'(1), 6'h05);
        begin_cycle();
        chk("miss_issue", 64'(unit_req_valid_o), 64'd0);
        chk("miss_qready", 64'(q_ready_o), 64'd1);
        end_cycle();
        q_valid_i = 1'b0;
        begin_cycle();
        chk("miss_p_early", 64'(p_valid_o), 64'd0);
        end_cycle();
        begin_cycle();
        chk("miss_p_valid", 64'(p_valid_o), 64'd1);
        chk("miss_p_id", 64'(p_id_o), 64'h05);
        chk("miss_p_data", 64'(p_data_o), 64'd0);
        chk("miss_p_error", 64'(p_error_o), 64'd1);
        end_cycle();
        drain("miss_drain");

        // Ordering: hit 1 (slow), miss 2, hit 3; miss waits behind hit 1
        unit_req_ready_i = 1'b1; unit_lat = 5;
        set_req(ADDR, IW'(1));
        begin_cycle(); chk("ord_acc1", 64'(q_ready_o), 64'd1); end_cycle();
        set_req(AW'(2), IW'(2));
        begin_cycle(); chk("ord_acc2", 64'(q_ready_o), 64'd1); end_cycle();
        unit_lat = 2;
        set_req(ADDR, IW'(3));
        begin_cycle(); chk("ord_acc3", 64'(q_ready_o), 64'd1); end_cycle();
        q_valid_i = 1'b0;
        for (int k = 3; k <= 9; k++) begin
            begin_cycle();
            if (k <= 5) chk("ord_wait", 64'(p_valid_o), 64'd0);
            if (k == 5) chk("ord_rsp1_ready", 64'(unit_rsp_ready_o), 64'd1);
            if (k == 6) begin
                chk("ord_beat1", 64'({p_valid_o, p_id_o}), 64'({1'b1, IW'(1)}));
                chk("ord_rsp3_offered", 64'(unit_rsp_valid_i), 64'd1);
                chk("ord_miss_head_block", 64'(unit_rsp_ready_o), 64'd0);
            end
            if (k == 7) begin
                chk("ord_beat2", 64'({p_valid_o, p_id_o, p_error_o}), 64'({1'b1, IW'(2), 1'b1}));
                chk("ord_rsp3_ready", 64'(unit_rsp_ready_o), 64'd1);
            end
            if (k == 8) chk("ord_beat3", 64'({p_valid_o, p_id_o}), 64'({1'b1, IW'(3)}));
            if (k == 9) chk("ord_done", 64'(p_valid_o), 64'd0);
            end_cycle();
        end
        drain("ord_drain");

        // Full: four hits accepted, fifth refused until the cycle after a pop
        unit_hold = 1'b1; unit_lat = 1; unit_req_ready_i = 1'b1; p_ready_i = 1'b1;
        for (int k = 0; k < MAXO; k++) begin
            set_req(ADDR, IW'(16 + k));
            begin_cycle(); chk("full_acc", 64'(q_ready_o), 64'd1); end_cycle();
        end
        set_req(ADDR, IW'(32));
        begin_cycle();
        chk("full_qready", 64'(q_ready_o), 64'd0);
        chk("full_issue", 64'(unit_req_valid_o), 64'd0);
        end_cycle();
        unit_hold = 1'b0;
        begin_cycle();
        chk("full_pop_qready", 64'(q_ready_o), 64'd0);
        chk("full_pop_rsp", 64'(unit_rsp_ready_o & unit_rsp_valid_i), 64'd1);
        end_cycle();
        unit_hold = 1'b1;
        begin_cycle();
        chk("full_after_pop_qready", 64'(q_ready_o), 64'd1);
        end_cycle();
        chk("full_fifth_accepted", 64'(last_acc), 64'd1);
        q_valid_i = 1'b0;
        drain("full_drain");

        // Backpressure then back-to-back streaming
        unit_hold = 1'b1; unit_lat = 1; p_ready_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            set_req(ADDR, IW'(40 + k));
            begin_cycle(); end_cycle();
        end
        q_valid_i = 1'b0; unit_hold = 1'b0; p_ready_i = 1'b0;
        begin_cycle();
        chk("bp_first_load", 64'(unit_rsp_ready_o), 64'd1);
        end_cycle();
        for (int k = 1; k <= 4; k++) begin
            begin_cycle();
            chk("bp_hold_valid", 64'(p_valid_o), 64'd1);
            chk("bp_hold_beat", 64'({p_id_o, p_data_o, p_error_o}), 64'(exp_q[0]));
            chk("bp_rsp_blocked", 64'(unit_rsp_ready_o), 64'd0);
            end_cycle();
        end
        p_ready_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            begin_cycle();
            chk("bp_stream_valid", 64'(p_valid_o), 64'd1);
            end_cycle();
        end
        begin_cycle();
        chk("bp_stream_end", 64'(p_valid_o), 64'd0);
        end_cycle();
        drain("bp_drain");

        // Reset with three outstanding hits
        unit_hold = 1'b1; unit_req_ready_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            set_req(ADDR, IW'(50 + k));
            begin_cycle(); end_cycle();
        end
        do_reset();
        set_req(ADDR, IW'(60));
        unit_req_ready_i = 1'b1;
        #2;
        chk("rstmid_p_valid", 64'(p_valid_o), 64'd0);
        chk("rstmid_q_ready", 64'(q_ready_o), 64'd1);
        chk("rstmid_rsp_ready", 64'(unit_rsp_ready_o), 64'd0);
        q_valid_i = 1'b0;
        @(posedge clk_i);
        #1;
        cyc++;
        begin_cycle();
        chk("rstmid_still_idle", 64'(p_valid_o), 64'd0);
        end_cycle();
        unit_hold = 1'b0;

        // Randomized traffic against the expected-response queue
        for (int n = 0; n < 2000; n++) begin
            if (!q_valid_i && $urandom_range(0, 99) < 60) begin
                if ($urandom_range(0, 3) == 0) set_req(AW'($urandom_range(1, 15)), IW'($urandom_range(0, 63)));
                else set_req(ADDR, IW'($urandom_range(0, 63)));
            end
            unit_req_ready_i = ($urandom_range(0, 3) != 0);
            p_ready_i        = ($urandom_range(0, 3) != 0);
            unit_hold        = ($urandom_range(0, 4) == 0);
            unit_lat         = $urandom_range(1, 3);
            begin_cycle();
            end_cycle();
            if (last_acc) q_valid_i = 1'b0;
        end
        drain("rand_drain");
        chk("rand_unit_idle", 64'(pend_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
